// File: rtl/fp_div_pkg.sv
// Shared types and constants for the iterative single-precision divider.
package fp_div_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;
    localparam int ITER_N = 27;
    localparam int CNT_W  = 5;

    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] signed_inf(input logic sign);
        return {sign, POS_INF[30:0]};
    endfunction

    function automatic logic [31:0] signed_zero(input logic sign);
        return {sign, POS_ZERO[30:0]};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational decode of an IEEE-754 single word into zero/denormal/inf/nan.
module fp_classify
    import fp_div_pkg::*;
(
    input  logic [31:0] word_i,
    output logic        zero_o,
    output logic        denorm_o,
    output logic        inf_o,
    output logic        nan_o
);

    logic exp_zero;
    logic exp_ones;
    logic man_zero;

    assign exp_zero = (word_i[MAN_W +: EXP_W] == '0);
    assign exp_ones = (word_i[MAN_W +: EXP_W] == '1);
    assign man_zero = (word_i[MAN_W-1:0] == '0);

    assign zero_o   = exp_zero &  man_zero;
    assign denorm_o = exp_zero & ~man_zero;
    assign inf_o    = exp_ones &  man_zero;
    assign nan_o    = exp_ones & ~man_zero;

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 single divider: restoring division, round-to-nearest-even, fixed 29-cycle latency.
// Optional status flags {invalid, div_by_zero, overflow, underflow} with FP_DIV_STATUS_EN.
module fp_div_iter
    import fp_div_pkg::*;
#(
    parameter logic [31:0] QNAN_VALUE = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
`ifdef FP_DIV_STATUS_EN
    output logic [3:0]  status,
`endif
    output state_e      state_dbg
);

    // Handshake: a pair transfers on a rising edge with in_valid & in_ready; the
    // quotient transfers on a rising edge with out_valid & out_ready. Both sides
    // hold their payload stable while valid is high and ready is low.

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        mb_q;
    logic [24:0]        rem_q;
    logic [26:0]        quo_q;
    logic               sticky_q;
    logic               spec_q;
    logic [31:0]        spec_res_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [31:0]        result_q;
`ifdef FP_DIV_STATUS_EN
    logic [3:0]         spec_flags_q;
    logic [3:0]         status_q;
    logic [3:0]         spec_flags_d;
    logic [3:0]         status_d;
`endif

    logic a_zero_w, a_den_w, a_inf_w, a_nan_w;
    logic b_zero_w, b_den_w, b_inf_w, b_nan_w;

    fp_classify u_class_a (
        .word_i   (a),
        .zero_o   (a_zero_w),
        .denorm_o (a_den_w),
        .inf_o    (a_inf_w),
        .nan_o    (a_nan_w)
    );

    fp_classify u_class_b (
        .word_i   (b),
        .zero_o   (b_zero_w),
        .denorm_o (b_den_w),
        .inf_o    (b_inf_w),
        .nan_o    (b_nan_w)
    );

    logic              in_sign;
    logic              a_z;
    logic              b_z;
    logic              spec_hit_d;
    logic [31:0]       spec_res_d;
    logic signed [9:0] exp_d;

    assign in_sign = a[31] ^ b[31];
    // Denormal operands are flushed to zero before any special-case decision.
    assign a_z     = a_zero_w | a_den_w;
    assign b_z     = b_zero_w | b_den_w;
    assign exp_d   = 10'({2'b00, a[30:23]}) - 10'({2'b00, b[30:23]}) + 10'(BIAS);

    always_comb begin
        spec_hit_d = 1'b1;
        spec_res_d = QNAN_VALUE;
`ifdef FP_DIV_STATUS_EN
        spec_flags_d = 4'b1000;
`endif
        if (a_nan_w || b_nan_w || (a_z && b_z) || (a_inf_w && b_inf_w)) begin
            spec_res_d = QNAN_VALUE;
        end else if (a_inf_w) begin
            spec_res_d = signed_inf(in_sign);
`ifdef FP_DIV_STATUS_EN
            spec_flags_d = 4'b0000;
`endif
        end else if (b_z) begin
            spec_res_d = signed_inf(in_sign);
`ifdef FP_DIV_STATUS_EN
            spec_flags_d = 4'b0100;
`endif
        end else if (a_z || b_inf_w) begin
            spec_res_d = signed_zero(in_sign);
`ifdef FP_DIV_STATUS_EN
            spec_flags_d = 4'b0000;
`endif
        end else begin
            spec_hit_d = 1'b0;
`ifdef FP_DIV_STATUS_EN
            spec_flags_d = 4'b0000;
`endif
        end
    end

    // One restoring step: compare, conditionally subtract, shift remainder left.
    logic        rem_ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_d;
    logic [26:0] quo_d;

    assign rem_ge  = (rem_q >= {1'b0, mb_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    assign rem_d   = rem_sub << 1;
    assign quo_d   = {quo_q[25:0], rem_ge};

    logic              round_up;
    logic [24:0]       mant_sum;
    logic [22:0]       frac_r;
    logic signed [9:0] exp_r;
    logic              ovf_r;
    logic              unf_r;
    logic [31:0]       pack_d;

    // quo_q is already normalized here: [26:3] mantissa, [2] guard, the rest sticky.
    assign round_up = quo_q[2] & (quo_q[3] | (|quo_q[1:0]) | sticky_q);
    assign mant_sum = {1'b0, quo_q[26:3]} + {24'd0, round_up};
    assign frac_r   = mant_sum[24] ? mant_sum[23:1] : mant_sum[22:0];
    assign exp_r    = exp_q + 10'(mant_sum[24]);
    assign ovf_r    = (exp_r > 10'sd254);
    assign unf_r    = (exp_r < 10'sd1);

    always_comb begin
        pack_d = {sign_q, exp_r[7:0], frac_r};
        if (spec_q) begin
            pack_d = spec_res_q;
        end else if (ovf_r) begin
            pack_d = signed_inf(sign_q);
        end else if (unf_r) begin
            pack_d = signed_zero(sign_q);
        end
    end

`ifdef FP_DIV_STATUS_EN
    assign status_d = spec_q ? spec_flags_q : {2'b00, ovf_r, unf_r};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mb_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            sticky_q    <= 1'b0;
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
`ifdef FP_DIV_STATUS_EN
            spec_flags_q <= '0;
            status_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sign_q     <= in_sign;
                        exp_q      <= exp_d;
                        mb_q       <= {1'b1, b[22:0]};
                        rem_q      <= {2'b01, a[22:0]};
                        quo_q      <= '0;
                        sticky_q   <= 1'b0;
                        spec_q     <= spec_hit_d;
                        spec_res_q <= spec_res_d;
`ifdef FP_DIV_STATUS_EN
                        spec_flags_q <= spec_flags_d;
`endif
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == CNT_W'(ITER_N - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_ROUND;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ROUND: begin
                    // Two steps: normalize/sticky first, then round and pack.
                    if (cnt_q == '0) begin
                        if (!quo_q[26]) begin
                            quo_q <= {quo_q[25:0], 1'b0};
                            exp_q <= exp_q - 10'sd1;
                        end
                        sticky_q <= |rem_q;
                        cnt_q    <= cnt_q + 1'b1;
                    end else begin
                        result_q    <= pack_d;
`ifdef FP_DIV_STATUS_EN
                        status_q    <= status_d;
`endif
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign state_dbg = state_q;
`ifdef FP_DIV_STATUS_EN
    assign status    = status_q;
`endif

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed self-checking bench for fp_div_iter: latency, rounding, special cases, backpressure, reset.
module tb_fp_div_iter;
  import fp_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  state_e      state_dbg;
`ifdef FP_DIV_STATUS_EN
  logic [3:0]  status;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fp_div_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef FP_DIV_STATUS_EN
    .status    (status),
`endif
    .state_dbg (state_dbg)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: offer a pair and return just after the accepting edge.
  task automatic send(input logic [31:0] av, input logic [31:0] bv);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_wait: in_ready=%0b required=1", in_ready);
    end
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL wait_out_timeout: out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%0b want=0", out_valid); end
    total++;
    if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got=%h want=00000000", result); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%0b want=1", in_ready); end
    total++;
    if (state_dbg !== S_IDLE) begin bad++; $display("FAIL reset_state: got=%0d want=%0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_latency();
    int lat;
    send(32'h40C0_0000, 32'h4000_0000);
    wait_out(lat);
    total++;
    if (lat !== 29) begin bad++; $display("FAIL latency_6_2: got=%0d want=29", lat); end
    total++;
    if (result !== 32'h4040_0000) begin bad++; $display("FAIL result_6_2: got=%h want=40400000", result); end
    take();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL handshake_6_2: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [20] = '{
      32'h3F80_0000, 32'h4000_0000, 32'hC0C0_0000, 32'h4110_0000, 32'h3F80_0000,
      32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h7FC0_0001,
      32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000, 32'h40A0_0000, 32'h0000_0001,
      32'h3F80_0000, 32'h7F7F_FFFF, 32'h0080_0000, 32'h8080_0000, 32'h0100_0000};
    logic [31:0] vb [20] = '{
      32'h4040_0000, 32'h4040_0000, 32'h4000_0000, 32'h4040_0000, 32'h4000_0000,
      32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000,
      32'h7F80_0000, 32'h4000_0000, 32'h40A0_0000, 32'hFF80_0000, 32'h3F80_0000,
      32'h0000_0001, 32'h3F00_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    logic [31:0] ve [20] = '{
      32'h3EAA_AAAB, 32'h3F2A_AAAB, 32'hC040_0000, 32'h4040_0000, 32'h3F00_0000,
      32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000,
      32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000,
      32'h7F80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h8000_0000, 32'h0080_0000};
`ifdef FP_DIV_STATUS_EN
    logic [3:0] vs [20] = '{
      4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
      4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b1000,
      4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
      4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0000};
`endif
    int lat;
    for (int i = 0; i < 20; i++) begin
      send(va[i], vb[i]);
      wait_out(lat);
      total++;
      if (lat !== 29) begin bad++; $display("FAIL vec%0d_latency: got=%0d want=29", i, lat); end
      total++;
      if (result !== ve[i]) begin
        bad++; $display("FAIL vec%0d_result: a=%h b=%h got=%h want=%h", i, va[i], vb[i], result, ve[i]);
      end
`ifdef FP_DIV_STATUS_EN
      total++;
      if (status !== vs[i]) begin bad++; $display("FAIL vec%0d_status: got=%b want=%b", i, status, vs[i]); end
`endif
      take();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int stall_bad = 0;
    send(32'h3F80_0000, 32'h4040_0000);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || result !== 32'h3EAA_AAAB || in_ready !== 1'b0) begin
        bad++; stall_bad++;
        $display("FAIL stall%0d: out_valid=%0b result=%h in_ready=%0b want 1/3eaaaaab/0",
                 i, out_valid, result, in_ready);
      end
    end
    take();
    total++;
    if (state_dbg !== S_IDLE || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release: state=%0d in_ready=%0b out_valid=%0b want 0/1/0",
                      state_dbg, in_ready, out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (result !== 32'h3EAA_AAAB) begin bad++; $display("FAIL result_hold: got=%h want=3eaaaaab", result); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] want;
    send(32'h4110_0000, 32'h4040_0000);
    exp_q.push_back(32'h4040_0000);
    wait_out(lat);
    want = exp_q.pop_front();
    total++;
    if (result !== want) begin bad++; $display("FAIL b2b_first: got=%h want=%h", result, want); end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 32'h3F80_0000;
    b = 32'h4000_0000;
    exp_q.push_back(32'h3F00_0000);
    @(posedge clk);
    #1 out_ready = 1'b0;
    total++;
    if (state_dbg !== S_IDLE || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_no_accept_on_done: state=%0d in_ready=%0b want 0/1", state_dbg, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    total++;
    if (state_dbg !== S_CALC || in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_accept: state=%0d in_ready=%0b want 1/0", state_dbg, in_ready);
    end
    wait_out(lat);
    want = exp_q.pop_front();
    total++;
    if (lat !== 29) begin bad++; $display("FAIL b2b_latency: got=%0d want=29", lat); end
    total++;
    if (result !== want) begin bad++; $display("FAIL b2b_second: got=%h want=%h", result, want); end
    take();
  endtask

  task automatic test_reset_mid();
    int lat;
    int stale = 0;
    send(32'h40C0_0000, 32'h4000_0000);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_async: out_valid=%0b result=%h in_ready=%0b want 0/00000000/1",
                      out_valid, result, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || state_dbg !== S_IDLE) stale++;
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL midreset_stale: cycles_active=%0d want=0", stale); end
    send(32'h40C0_0000, 32'h4000_0000);
    wait_out(lat);
    total++;
    if (lat !== 29 || result !== 32'h4040_0000) begin
      bad++; $display("FAIL midreset_next: lat=%0d result=%h want 29/40400000", lat, result);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_div_iter.md
FP_DIV_ITER -- requirements
Module: fp_div_iter

Interface
REQ-001 SHALL have parameter QNAN_VALUE, default 32'h7FC0_0000, the canonical quiet NaN driven for every NaN result.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, dividend/divisor pair valid.
REQ-005 SHALL have port in_ready, output, 1 bit, block can accept a pair.
REQ-006 SHALL have port a, input, 32 bits, IEEE-754 single dividend.
REQ-007 SHALL have port b, input, 32 bits, IEEE-754 single divisor.
REQ-008 SHALL have port out_valid, output, 1 bit, quotient valid.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer accepts the quotient.
REQ-010 SHALL have port result, output, 32 bits, quotient a/b.
REQ-011 SHALL have port status, output, 4 bits, {invalid, div_by_zero, overflow, underflow}; present only under FP_DIV_STATUS_EN.

Function
REQ-012 SHALL implement states IDLE, CALC, ROUND, DONE; in_ready=1 only in IDLE.
REQ-013 SHALL accept on in_valid&in_ready: latch a, b, sign = a[31]^b[31], biased exponent difference +127, and mantissas with hidden bit; IDLE->CALC.
REQ-014 SHALL in CALC run one restoring quotient bit per cycle for exactly 27 cycles (24 mantissa + guard + round + normalize bit), then CALC->ROUND.
REQ-015 SHALL in ROUND normalize a quotient below 1.0 by one left shift with exponent decrement, form sticky from the non-zero remainder, round to nearest even, renormalize on mantissa carry, then ROUND->DONE.
REQ-016 SHALL assert out_valid exactly 29 cycles after the accepting edge, including special-case operands (fixed latency).
REQ-017 SHALL hold result and out_valid stable in DONE until out_ready=1, then DONE->IDLE; a new pair SHALL NOT be accepted in the same cycle as the DONE handshake.
REQ-018 SHALL treat denormal inputs as zero and flush a result with exponent below 1 to signed zero.
REQ-019 SHALL return signed infinity on rounded exponent above 254.
REQ-020 SHALL return, overriding REQ-014/015: NaN input, 0/0 or inf/inf -> QNAN_VALUE; x/0 with x finite non-zero -> signed inf; inf/x with x finite -> signed inf; 0/x or x/inf -> signed zero.
REQ-021 SHALL hold result at its last value after the handshake until the next DONE.

Reset
REQ-022 SHALL on rst_n=0, asynchronously: state=IDLE, in_ready=1 after release, out_valid=0, result=0, status=0, iteration counter=0.
REQ-023 SHALL discard any in-flight division on reset mid-operation; no stale out_valid after release.

Configuration
REQ-024 SHALL, with FP_DIV_STATUS_EN defined, provide status registered together with result and held with it in DONE: invalid for the QNAN_VALUE cases, div_by_zero for finite non-zero/0, overflow per REQ-019, underflow per REQ-018 flush.
REQ-025 SHALL, without FP_DIV_STATUS_EN, omit the status port and its flag logic entirely; all other behaviour is identical.

Structure
REQ-026 SHALL place the state enum, field widths (EXP_W=8, MAN_W=23, BIAS=127), the iteration count 27 and the infinity/zero constants in shared package fp_div_pkg.
REQ-027 SHALL use one sub-module, fp_classify, combinational, decoding a 32-bit word into zero/denormal/inf/nan flags; instantiated once per operand.

Verification
REQ-028 SHALL cover: a=0x40C00000 (6.0), b=0x40000000 (2.0) -> result 0x40400000 after 29 cycles.
REQ-029 SHALL cover: a=0x3F800000, b=0x40400000 -> result 0x3EAAAAAB (round-to-nearest-even up).
REQ-030 SHALL cover: a=0x3F800000, b=0x00000000 -> 0x7F800000, div_by_zero=1; and a=b=0 -> 0x7FC00000, invalid=1.
REQ-031 SHALL cover: a=0x7F7FFFFF, b=0x3F000000 -> 0x7F800000, overflow=1; a=0x00800000, b=0x40000000 -> 0x00000000, underflow=1.
REQ-032 SHALL cover: out_ready held 0 for 10 cycles in DONE -> result, out_valid stable and in_ready=0 throughout; handshake -> IDLE next cycle.
REQ-033 SHALL cover: rst_n pulsed low at cycle 12 of CALC -> out_valid=0, result=0, in_ready=1 after release; next pair 6.0/2.0 still returns 0x40400000.
